// File: rtl/osd_pixel_gen.sv
// OSD pixel generator: derives the OSD window from the VGA syncs and reads the
// character RAM and the external font ROM. The result goes to the overlay mixer
// three pix_ce later.
module osd_pixel_gen #(
    parameter int COLS     = 32,   // character columns, power of 2
    parameter int ROWS     = 16,   // character rows, power of 2
    parameter int H_START  = 128,  // window start, pixels after hsync trailing edge
    parameter int V_START  = 64,   // window start, lines after vsync trailing edge
    parameter int SYNC_POL = 0     // asserted sync level (0 = active-low)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_ce,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic        osd_enable,
    input  logic        wr_en,
    input  logic [8:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        osd_window,
    output logic        osd_pixel,
    output logic        frame_start
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int AW    = CW + RW;        // character RAM address width (at most 9)
    localparam int DEPTH = COLS * ROWS;

    localparam logic        SYNC_ACT = (SYNC_POL != 0);
    localparam logic [10:0] H_LO     = 11'(H_START);
    localparam logic [10:0] H_HI     = 11'(H_START + COLS * 8);
    localparam logic [9:0]  V_LO     = 10'(V_START);
    localparam logic [9:0]  V_HI     = 10'(V_START + ROWS * 8);

    // ------------------------------------------------------------------
    // Sync edge detection (every clk, independent of pix_ce)
    // ------------------------------------------------------------------
    logic hs_q, hs_prev_q, vs_q, vs_prev_q;
    logic hs_trail, vs_trail;

    // Register the syncs and keep the previous sample. Reset loads the deasserted
    // level so that releasing reset never creates a false trailing edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q      <= ~SYNC_ACT;
            hs_prev_q <= ~SYNC_ACT;
            vs_q      <= ~SYNC_ACT;
            vs_prev_q <= ~SYNC_ACT;
        end else begin
            hs_q      <= vga_hsync;
            hs_prev_q <= hs_q;
            vs_q      <= vga_vsync;
            vs_prev_q <= vs_q;
        end
    end

    assign hs_trail = (hs_prev_q == SYNC_ACT) && (hs_q != SYNC_ACT);
    assign vs_trail = (vs_prev_q == SYNC_ACT) && (vs_q != SYNC_ACT);

    // ------------------------------------------------------------------
    // Raster counters and frame-coherent enable latch
    // ------------------------------------------------------------------
    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        en_latch_q, en_latch_d;
    logic        frame_start_q;

    // Next-state for the saturating counters. A clear on the trailing edge wins over an increment.
    always_comb begin
        hcount_d = hcount_q;
        if (hs_trail)
            hcount_d = '0;
        else if (pix_ce && (hcount_q != 11'h7FF))
            hcount_d = hcount_q + 11'd1;

        vcount_d = vcount_q;
        if (vs_trail)
            vcount_d = '0;
        else if (hs_trail && (vcount_q != 10'h3FF))
            vcount_d = vcount_q + 10'd1;

        en_latch_d = vs_trail ? osd_enable : en_latch_q;
    end

    // Counter, latch and frame_start state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            en_latch_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            en_latch_q    <= en_latch_d;
            frame_start_q <= vs_trail;
        end
    end

    // ------------------------------------------------------------------
    // Window test and character addressing
    // ------------------------------------------------------------------
    logic [CW+2:0] hx;       // only the low bits of hcount-H_START are needed
    logic [RW+2:0] vy;
    logic          inwin;
    logic [AW-1:0] rd_addr;

    assign hx      = hcount_q[CW+2:0] - H_LO[CW+2:0];
    assign vy      = vcount_q[RW+2:0] - V_LO[RW+2:0];
    assign inwin   = en_latch_q
                   && (hcount_q >= H_LO) && (hcount_q < H_HI)
                   && (vcount_q >= V_LO) && (vcount_q < V_HI);
    assign rd_addr = {vy[RW+2:3], hx[CW+2:3]};

    // ------------------------------------------------------------------
    // Character RAM write port with out-of-range guard
    // ------------------------------------------------------------------
    logic          wr_ok;
    logic [AW-1:0] wr_idx;

    assign wr_idx = wr_addr[AW-1:0];

    generate
        if (DEPTH < 512) begin : g_wr_guard
            // Addresses beyond the RAM are dropped rather than folded back onto it.
            assign wr_ok = (wr_addr < 9'(DEPTH));
        end else begin : g_wr_full
            // The 9-bit address cannot exceed the RAM, so every write is in range.
            assign wr_ok = 1'b1;
        end
    endgenerate

    logic [7:0] char_mem [DEPTH];

    // Character RAM storage (contents are not reset).
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok)
            char_mem[wr_idx] <= wr_data;
    end

    // ------------------------------------------------------------------
    // Three-stage pixel pipeline, advancing on pix_ce
    // ------------------------------------------------------------------
    logic [7:0]  char_q;
    logic        win_s1_q, win_s2_q;
    logic [2:0]  bit_s1_q, bit_s2_q;
    logic [2:0]  line_s1_q;
    logic [10:0] font_addr_q;
    logic        osd_window_q, osd_pixel_q;

    // S1: synchronous character read. A same-address write in this clk is not seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            char_q <= '0;
        else if (pix_ce)
            char_q <= char_mem[rd_addr];
    end

    // S1..S3 control and output registers. Holding pix_ce low freezes every stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_s1_q     <= 1'b0;
            bit_s1_q     <= '0;
            line_s1_q    <= '0;
            font_addr_q  <= '0;
            win_s2_q     <= 1'b0;
            bit_s2_q     <= '0;
            osd_window_q <= 1'b0;
            osd_pixel_q  <= 1'b0;
        end else if (pix_ce) begin
            win_s1_q     <= inwin;
            bit_s1_q     <= hx[2:0];
            line_s1_q    <= vy[2:0];
            font_addr_q  <= {char_q, line_s1_q};
            win_s2_q     <= win_s1_q;
            bit_s2_q     <= bit_s1_q;
            osd_window_q <= win_s2_q;
            osd_pixel_q  <= win_s2_q & font_data[3'd7 - bit_s2_q];
        end
    end

    assign font_addr   = font_addr_q;
    assign osd_window  = osd_window_q;
    assign osd_pixel   = osd_pixel_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_osd_pixel_gen.sv
// Directed bench for osd_pixel_gen: drives sync timing, fills the character RAM,
// and checks the window, pixel, font address and frame_start outputs.
`timescale 1ns/1ps
module tb_osd_pixel_gen;

    localparam int COLS    = 32;
    localparam int ROWS    = 16;
    localparam int H_START = 128;
    localparam int V_START = 64;

    logic        clk = 1'b0;
    logic        reset_n, pix_ce, vga_hsync, vga_vsync, osd_enable, wr_en;
    logic [8:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic        osd_window, osd_pixel, frame_start;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    osd_pixel_gen #(
        .COLS(COLS), .ROWS(ROWS), .H_START(H_START), .V_START(V_START), .SYNC_POL(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .osd_enable(osd_enable),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .font_addr(font_addr), .font_data(font_data),
        .osd_window(osd_window), .osd_pixel(osd_pixel), .frame_start(frame_start)
    );

    // Font ROM: a real 'A' glyph for 0x41, an arbitrary but fixed pattern elsewhere.
    function automatic logic [7:0] font_rom(input logic [10:0] a);
        logic [7:0] c;
        c = a[10:3];
        if (c == 8'h41) begin
            case (a[2:0])
                3'd0: return 8'h18;
                3'd1: return 8'h3C;
                3'd2: return 8'h66;
                3'd3: return 8'h66;
                3'd4: return 8'h7E;
                3'd5: return 8'h66;
                3'd6: return 8'h66;
                default: return 8'h00;
            endcase
        end
        return c ^ {a[2:0], 5'b10110};
    endfunction

    assign font_data = font_rom(font_addr);

    // Reference state: RAM shadow, raster position, sync history, 3-deep output delay.
    logic [7:0]  shadow [512];
    int          hc, vc;
    bit          latch_m, fs_m;
    bit          hs_r, hs_p, vs_r, vs_p;
    bit          s1_w, s2_w, s3_w, s1_p, s2_p, s3_p;
    logic [10:0] s1_fa, s2_fa;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hc = 0; vc = 0; latch_m = 0; fs_m = 0;
        hs_r = 1; hs_p = 1; vs_r = 1; vs_p = 1;
        s1_w = 0; s2_w = 0; s3_w = 0; s1_p = 0; s2_p = 0; s3_p = 0;
        s1_fa = '0; s2_fa = '0;
    endtask

    // One clk: advance the reference with the inputs about to be sampled, then compare.
    task automatic tick();
        bit         hs_t, vs_t, w;
        int         hx, vy, addr;
        logic [7:0] g;
        if (!reset_n) begin
            model_reset();
        end else begin
            hs_t = !hs_p && hs_r;
            vs_t = !vs_p && vs_r;
            if (pix_ce) begin
                w = latch_m && (hc >= H_START) && (hc < H_START + COLS * 8)
                    && (vc >= V_START) && (vc < V_START + ROWS * 8);
                s3_w = s2_w; s3_p = s2_p;
                s2_w = s1_w; s2_p = s1_p; s2_fa = s1_fa;
                s1_w = w; s1_p = 0; s1_fa = '0;
                if (w) begin
                    hx    = hc - H_START;
                    vy    = vc - V_START;
                    addr  = (vy / 8) * COLS + hx / 8;
                    s1_fa = {shadow[addr], 3'(vy % 8)};
                    g     = font_rom(s1_fa);
                    s1_p  = g[7 - (hx % 8)];
                end
            end
            if (hs_t) hc = 0;
            else if (pix_ce && hc < 2047) hc++;
            if (vs_t) vc = 0;
            else if (hs_t && vc < 1023) vc++;
            if (vs_t) latch_m = osd_enable;
            fs_m = vs_t;
            hs_p = hs_r; hs_r = vga_hsync;
            vs_p = vs_r; vs_r = vga_vsync;
        end
        @(posedge clk);
        #1;
        chk("osd_window", 32'(osd_window), 32'(s3_w));
        chk("osd_pixel", 32'(osd_pixel), 32'(s3_p));
        chk("frame_start", 32'(frame_start), 32'(fs_m));
        if (!reset_n)
            chk("font_addr_rst", 32'(font_addr), 32'd0);
        else if (s2_w)
            chk("font_addr", 32'(font_addr), 32'(s2_fa));
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_en = 1; wr_addr = 9'(a); wr_data = d;
        tick();
        wr_en = 0;
        shadow[a] = d;
    endtask

    task automatic vsync_pulse(output logic [2:0] fs_seen);
        vga_vsync = 0; tick(); tick(); vga_vsync = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            fs_seen = {fs_seen[1:0], frame_start};
        end
    endtask

    task automatic short_lines(input int n);
        for (int i = 0; i < n; i++) begin
            vga_hsync = 0; tick(); tick(); vga_hsync = 1;
            repeat (4) tick();
        end
    endtask

    // Hsync pulse then len clks; k counts clks after hsync is released.
    task automatic run_line(input int len, input int ce_div, input int reset_at, input int fa_k,
                            output int rise, output int win_ticks,
                            output logic [7:0] pix8, output logic [10:0] fa_seen);
        int idx;
        rise = -1; win_ticks = 0; pix8 = '0; fa_seen = '0; idx = 0;
        pix_ce = 1; vga_hsync = 0; tick(); tick(); vga_hsync = 1;
        for (int k = 1; k <= len; k++) begin
            if (k == reset_at) begin
                chk("win_before_rst", 32'(osd_window), 32'd1);
                reset_n = 0;
                #1;
                chk("rst_async_window", 32'(osd_window), 32'd0);
                chk("rst_async_pixel", 32'(osd_pixel), 32'd0);
                chk("rst_async_font_addr", 32'(font_addr), 32'd0);
                model_reset();
                tick(); tick();
                reset_n = 1;
            end
            pix_ce = ((k % ce_div) == 0);
            tick();
            if (osd_window) begin
                win_ticks++;
                if (rise < 0) rise = k;
            end
            if (rise >= 0 && idx < 8 && ((k - rise) % ce_div) == 0) begin
                pix8 = {pix8[6:0], osd_pixel};
                idx++;
            end
            if (k == fa_k) fa_seen = font_addr;
        end
        pix_ce = 1;
    endtask

    initial begin
        int          rise, wt;
        logic [7:0]  p8;
        logic [10:0] fa;
        logic [2:0]  fs;

        reset_n = 0; pix_ce = 0; vga_hsync = 1; vga_vsync = 1;
        osd_enable = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
        model_reset();

        // 1: reset held while syncs toggle -> all outputs stay 0
        for (int i = 0; i < 8; i++) begin
            vga_hsync = i[0]; vga_vsync = i[1];
            tick();
        end
        vga_hsync = 1; vga_vsync = 1;
        tick();
        reset_n = 1; pix_ce = 1;

        // Fill the whole character RAM with a known pattern, then 'A' in cell 0
        for (int i = 0; i < 512; i++) wr(i, 8'(i * 7 + 3));
        wr(0, 8'h41);

        // 2: one frame with 'A' in cell 0
        osd_enable = 1;
        vsync_pulse(fs);
        chk("frame_start_pulse", 32'(fs), 32'b010);
        short_lines(V_START - 1);
        run_line(400, 1, -1, 132, rise, wt, p8, fa);
        chk("t2_rise_clk", 32'(rise), 32'd133);
        chk("t2_win_len", 32'(wt), 32'd256);
        chk("t2_font_addr", 32'(fa), 32'h208);
        chk("t2_pix_row0", 32'(p8), 32'h18);

        // 3 + 4: last cell gets 0x7F; enable dropped mid-frame keeps the window on
        wr(511, 8'h7F);
        vsync_pulse(fs);
        short_lines(V_START - 1);
        run_line(400, 1, -1, 132, rise, wt, p8, fa);
        chk("t3_cell0_font_addr", 32'(fa), 32'h208);
        osd_enable = 0;
        short_lines(119);
        run_line(400, 1, -1, 380, rise, wt, p8, fa);
        chk("t3_last_cell_font_addr", 32'(fa), 32'h3F8);
        chk("t4_win_persists", 32'(wt), 32'd256);

        // 4: next frame samples enable=0 -> no window
        vsync_pulse(fs);
        short_lines(V_START - 1);
        run_line(400, 1, -1, 132, rise, wt, p8, fa);
        chk("t4_win_off", 32'(wt), 32'd0);

        // 5: pix_ce 1-in-4 -> same pixels, each held 4 clk
        osd_enable = 1;
        vsync_pulse(fs);
        short_lines(V_START - 1);
        run_line(1560, 4, -1, 0, rise, wt, p8, fa);
        chk("t5_rise_clk", 32'(rise), 32'd524);
        chk("t5_win_len", 32'(wt), 32'd1024);
        chk("t5_pix_row0", 32'(p8), 32'h18);

        // 6: reset mid-line; nothing shown until the next vsync trailing edge
        run_line(400, 1, 200, 0, rise, wt, p8, fa);
        run_line(400, 1, -1, 0, rise, wt, p8, fa);
        chk("t6_win_off_after_rst", 32'(wt), 32'd0);
        vsync_pulse(fs);
        chk("t6_frame_start_pulse", 32'(fs), 32'b010);
        short_lines(V_START - 1);
        run_line(400, 1, -1, 132, rise, wt, p8, fa);
        chk("t6_rise_clk", 32'(rise), 32'd133);
        chk("t6_pix_row0", 32'(p8), 32'h18);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
